// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared width derivations and defaults for the PE array,
//               its wrapper and the output collector.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

  // Default number of valid beats between row r and row r+1 of one window.
  localparam int VERTICAL_SKEW_DEFAULT = 2;

  // Width of one row partial sum: product width plus growth over K taps.
  function automatic int sum_width(input int data_w, input int weight_w, input int k);
    return data_w + weight_w + k;
  endfunction

  // Width of the sum of K row sums; K-way addition cannot overflow this.
  function automatic int out_width(input int sum_w, input int k);
    return sum_w + $clog2(k);
  endfunction

  // Beats needed before the first window has all rows aligned.
  function automatic int warmup_beats(input int k, input int skew);
    return (k - 1) * skew;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pe_result_fifo
// Description : Synchronous result FIFO with occupancy count, drop-on-full
//               sticky overflow flag and simultaneous push/pop support.
//               The head output holds the last popped value while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_result_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] hold;
  logic             is_empty;
  logic             is_full;
  logic             pop;
  logic             wr_en;
  logic             flush;

  assign flush    = !rstn || clear;
  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  // A pop only exists when there is something to pop.
  assign pop      = !is_empty && pop_ready;
  // When full, a same-edge pop frees the slot the push lands in.
  assign wr_en    = push && (!is_full || pop);

  // Storage array; contents are only observed through the count-qualified head.
  always_ff @(posedge clk) begin
    if (!flush && wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, overflow and the hold register for the empty case.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      hold     <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head       = is_empty ? hold : mem[rd_ptr];
  assign head_valid = !is_empty;

endmodule
`default_nettype wire

// File: rtl/pe_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : pe_output_collector
// Description : Deskews the row-skewed partial-sum bus of pe_wrapper, adds
//               the aligned rows into one result per window and buffers the
//               results in a valid/ready FIFO. The source cannot stall, so a
//               full buffer drops results and raises a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_output_collector
  import pe_pkg::*;
#(
  parameter int KERNEL_SIZE   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int VERTICAL_SKEW = VERTICAL_SKEW_DEFAULT,
  parameter int FIFO_DEPTH    = 8,
  localparam int SUM_WIDTH    = sum_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE),
  localparam int OUT_WIDTH    = out_width(SUM_WIDTH, KERNEL_SIZE)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clear,
  input  logic [SUM_WIDTH*KERNEL_SIZE-1:0] sumIn,
  input  logic                             sumIn_valid,
  output logic [OUT_WIDTH-1:0]             result,
  output logic                             result_valid,
  input  logic                             result_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow
);

  localparam int WARMUP = warmup_beats(KERNEL_SIZE, VERTICAL_SKEW);
  localparam int WU_W   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WU_W-1:0] WARMUP_CNT = WU_W'(WARMUP);

  logic                                  flush;
  logic                                  beat;
  logic                                  window_done;
  logic [KERNEL_SIZE-1:0][SUM_WIDTH-1:0] taps;
  logic [WU_W-1:0]                       warm_cnt;
  logic [OUT_WIDTH-1:0]                  window_sum;
  logic                                  stage_valid;
  logic [OUT_WIDTH-1:0]                  stage_sum;
  logic                                  push_valid;
  logic [OUT_WIDTH-1:0]                  push_sum;

  // Clear behaves exactly like reset; reset simply being checked first is moot.
  assign flush       = !rstn || clear;
  assign beat        = sumIn_valid;
  assign window_done = beat && (warm_cnt == WARMUP_CNT);

  // Row r arrives (K-1-r)*SKEW beats before the last row of the same window,
  // so each row is delayed by that many beats to line them up.
  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
    localparam int DELAY = (KERNEL_SIZE - 1 - r) * VERTICAL_SKEW;
    logic [SUM_WIDTH-1:0] row_in;
    assign row_in = sumIn[r*SUM_WIDTH +: SUM_WIDTH];

    if (DELAY == 0) begin : g_direct
      assign taps[r] = row_in;
    end else begin : g_delay
      logic [SUM_WIDTH-1:0] line [DELAY];

      // Beat-gated shift register; idle cycles hold the line.
      always_ff @(posedge clk) begin
        if (flush) begin
          for (int i = 0; i < DELAY; i++) begin
            line[i] <= '0;
          end
        end else if (beat) begin
          line[0] <= row_in;
          for (int i = 1; i < DELAY; i++) begin
            line[i] <= line[i-1];
          end
        end
      end

      assign taps[r] = line[DELAY-1];
    end
  end

  // Zero-extend every aligned tap and add; OUT_WIDTH leaves room for the carry.
  always_comb begin
    window_sum = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      window_sum = window_sum + OUT_WIDTH'(taps[r]);
    end
  end

  // Warm-up counter and sum stage: a result is captured only once all rows are aligned.
  always_ff @(posedge clk) begin
    if (flush) begin
      warm_cnt    <= '0;
      stage_valid <= 1'b0;
      stage_sum   <= '0;
    end else begin
      stage_valid <= window_done;
      if (window_done) begin
        stage_sum <= window_sum;
      end
      if (beat && (warm_cnt != WARMUP_CNT)) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  // Push register keeps the adder output off the FIFO full/write-enable path.
  always_ff @(posedge clk) begin
    if (flush) begin
      push_valid <= 1'b0;
      push_sum   <= '0;
    end else begin
      push_valid <= stage_valid;
      push_sum   <= stage_sum;
    end
  end

  pe_result_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .push       (push_valid),
    .push_data  (push_sum),
    .pop_ready  (result_ready),
    .head       (result),
    .head_valid (result_valid),
    .count      (fifo_count),
    .overflow   (overflow)
  );

endmodule
`default_nettype wire
